// File: rtl/sdram_bridge.sv
// Plasma CPU memory port to SDRAM controller bridge: word/byte access translation,
// read-modify-write for partial stores, refresh scheduling. Optional read buffer: SDRAM_BRIDGE_RDBUF_EN.
module sdram_bridge #(
    parameter int REFRESH_CYCLES = 720
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_cpu_select,
    input  logic [29:0] I_cpu_address,
    input  logic [3:0]  I_cpu_byte_we,
    input  logic [31:0] I_cpu_data_w,
    output logic [31:0] O_cpu_data_r,
    output logic        O_cpu_pause,
    output logic        O_sdram_read,
    output logic        O_sdram_write,
    output logic        O_sdram_refresh,
    output logic [22:0] O_sdram_address,
    output logic [31:0] O_sdram_data,
    input  logic [31:0] I_sdram_data,
    input  logic        I_sdram_ready,
    input  logic        I_sdram_busy
);
    localparam int CW = $clog2(REFRESH_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, REF_ISSUE, REF_WAIT, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ref_cnt_q, ref_cnt_d;
    logic            ref_pending_q, ref_pending_d;
    logic            first_q, first_d;
    logic [22:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     merged;
    logic            ref_due;
    logic            rd_stb, wr_stb, ref_stb;
    logic            buf_hit;
    logic [31:0]     buf_rdata;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^I_cpu_address[29:23];

    // An expiry this cycle counts as pending so a colliding CPU select loses to refresh.
    assign ref_due = ref_pending_q || (ref_cnt_q == '0);

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged[gi*8 +: 8] = be_q[gi] ? wdata_q[gi*8 +: 8] : I_sdram_data[gi*8 +: 8];
    end

`ifdef SDRAM_BRIDGE_RDBUF_EN
    logic        buf_valid_q;
    logic [22:0] buf_addr_q;
    logic [31:0] buf_data_q;

    assign buf_hit   = buf_valid_q && (buf_addr_q == I_cpu_address[22:0]) && (I_cpu_byte_we == 4'd0);
    assign buf_rdata = buf_data_q;

    // Holds the last word seen on the SDRAM side; writes refresh it with the merged value.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else if (state_q == RD_WAIT && I_sdram_ready) begin
            buf_valid_q <= 1'b1;
            buf_addr_q  <= addr_q;
            buf_data_q  <= I_sdram_data;
        end else if (state_q == WR_WAIT && !first_q && !I_sdram_busy) begin
            buf_valid_q <= 1'b1;
            buf_addr_q  <= addr_q;
            buf_data_q  <= wdata_q;
        end
    end
`else
    assign buf_hit   = 1'b0;
    assign buf_rdata = '0;
`endif

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q       <= IDLE;
            ref_cnt_q     <= RELOAD;
            ref_pending_q <= 1'b0;
            first_q       <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            first_q       <= first_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ref_cnt_d     = (ref_cnt_q == '0) ? RELOAD : ref_cnt_q - 1'b1;
        ref_pending_d = (ref_pending_q && !ref_stb) || (ref_cnt_q == '0);
        first_d       = wr_stb || ref_stb;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (ref_due) begin
                    state_d = REF_ISSUE;
                end else if (I_cpu_select) begin
                    addr_d  = I_cpu_address[22:0];
                    be_d    = I_cpu_byte_we;
                    wdata_d = I_cpu_data_w;
                    if (buf_hit) begin
                        rdata_d = buf_rdata;
                        state_d = DONE;
                    end else if (I_cpu_byte_we == 4'hF) begin
                        state_d = WR_ISSUE;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            REF_ISSUE: if (!I_sdram_busy) state_d = REF_WAIT;
            REF_WAIT:  if (!first_q && !I_sdram_busy) state_d = IDLE;
            RD_ISSUE:  if (!I_sdram_busy) state_d = RD_WAIT;
            RD_WAIT: begin
                if (I_sdram_ready) begin
                    rdata_d = I_sdram_data;
                    if (be_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        wdata_d = merged;
                        state_d = WR_ISSUE;
                    end
                end
            end
            WR_ISSUE:  if (!I_sdram_busy) state_d = WR_WAIT;
            WR_WAIT:   if (!first_q && !I_sdram_busy) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_stb  = 1'b0;
        wr_stb  = 1'b0;
        ref_stb = 1'b0;
        case (state_q)
            REF_ISSUE: ref_stb = !I_sdram_busy;
            RD_ISSUE:  rd_stb  = !I_sdram_busy;
            WR_ISSUE:  wr_stb  = !I_sdram_busy;
            default: ;
        endcase
    end

    assign O_sdram_read    = rd_stb;
    assign O_sdram_write   = wr_stb;
    assign O_sdram_refresh = ref_stb;
    assign O_sdram_address = addr_q;
    assign O_sdram_data    = wdata_q;
    assign O_cpu_data_r    = rdata_q;
    assign O_cpu_pause     = I_cpu_select && (state_q != DONE);

endmodule
